// File: rtl/dcache_port_arbiter_if.sv
// Bus bundle between the fragment control units, the port arbiter and the data cache.
// The arbiter takes the slave view; whoever drives requests and models the cache takes the master view.
interface dcache_port_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 32,
   parameter int DW      = 32
);
   logic [NUM_REQ-1:0]    req_valid_i;
   logic [NUM_REQ*AW-1:0] req_addr_i;
   logic [NUM_REQ*DW-1:0] req_data_i;
   logic [NUM_REQ*3-1:0]  req_op_i;
   logic [NUM_REQ-1:0]    rsp_valid_o;
   logic [DW-1:0]         rsp_data_o;
   logic [AW-1:0]         dc_addr_o;
   logic [DW-1:0]         dc_data_o;
   logic [2:0]            dc_op_o;
   logic                  dc_valid_o;
   logic [DW-1:0]         dc_data_i;
   logic                  dc_valid_i;
   logic                  busy_o;
   logic                  err_o;

   modport slave (
      input  req_valid_i, req_addr_i, req_data_i, req_op_i, dc_data_i, dc_valid_i,
      output rsp_valid_o, rsp_data_o, dc_addr_o, dc_data_o, dc_op_o, dc_valid_o, busy_o, err_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_data_i, req_op_i, dc_data_i, dc_valid_i,
      input  rsp_valid_o, rsp_data_o, dc_addr_o, dc_data_o, dc_op_o, dc_valid_o, busy_o, err_o
   );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one data-cache port between NUM_REQ fragment control units.
// Request pulses are parked in per-requester slots; one cache transaction is in flight at a time,
// and a pulse arriving while the port is idle is granted in the same cycle straight from the inputs.
module dcache_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   dcache_port_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   pending_q, pending_d;
   logic [AW-1:0]        slotAddr_q [NUM_REQ];
   logic [DW-1:0]        slotData_q [NUM_REQ];
   logic [2:0]           slotOp_q   [NUM_REQ];
   logic [IDX_W-1:0]     rrPtr_q, rrPtr_d;
   logic [IDX_W-1:0]     grant_q, grant_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic                 dcValid_q, dcValid_d;
   logic [AW-1:0]        dcAddr_q, dcAddr_d;
   logic [DW-1:0]        dcData_q, dcData_d;
   logic [2:0]           dcOp_q, dcOp_d;
   logic [NUM_REQ-1:0]   rspValid_q, rspValid_d;
   logic [DW-1:0]        rspData_q, rspData_d;

   logic [NUM_REQ-1:0]   capture;
   logic [NUM_REQ-1:0]   eligible;
   logic                 arbFound;
   logic [IDX_W-1:0]     arbIdx;
   logic [IDX_W-1:0]     candIdx;
   logic [AW-1:0]        arbAddr;
   logic [DW-1:0]        arbData;
   logic [2:0]           arbOp;

   // A pulse is only accepted into a free slot; a pulse on an occupied slot is dropped and flagged.
   assign capture  = bus.req_valid_i & ~pending_q;
   assign eligible = pending_q | bus.req_valid_i;

   // Round-robin search from rrPtr_q and payload pick: parked slot if pending, otherwise the live input slice.
   always_comb begin
      arbFound = 1'b0;
      arbIdx   = '0;
      candIdx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         candIdx = IDX_W'((int'(rrPtr_q) + i) % NUM_REQ);
         if (!arbFound && eligible[candIdx]) begin
            arbFound = 1'b1;
            arbIdx   = candIdx;
         end
      end
      if (pending_q[arbIdx]) begin
         arbAddr = slotAddr_q[arbIdx];
         arbData = slotData_q[arbIdx];
         arbOp   = slotOp_q[arbIdx];
      end else begin
         arbAddr = bus.req_addr_i[AW*arbIdx +: AW];
         arbData = bus.req_data_i[DW*arbIdx +: DW];
         arbOp   = bus.req_op_i[3*arbIdx +: 3];
      end
   end

   // State register: IDLE waits for an eligible requester, WAIT holds until the cache answers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (arbFound) state_d = WAIT;
         WAIT: if (bus.dc_valid_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and bookkeeping next values: issue the cache pulse, route the response, track errors.
   always_comb begin
      pending_d  = pending_q | capture;
      rrPtr_d    = rrPtr_q;
      grant_d    = grant_q;
      dcValid_d  = 1'b0;
      dcAddr_d   = dcAddr_q;
      dcData_d   = dcData_q;
      dcOp_d     = dcOp_q;
      rspValid_d = '0;
      rspData_d  = rspData_q;
      err_d      = err_q | (|(bus.req_valid_i & pending_q));
      case (state_q)
         IDLE: begin
            if (bus.dc_valid_i) err_d = 1'b1;
            if (arbFound) begin
               grant_d   = arbIdx;
               dcValid_d = 1'b1;
               dcAddr_d  = arbAddr;
               dcData_d  = arbData;
               dcOp_d    = arbOp;
            end
         end
         WAIT: begin
            if (bus.dc_valid_i) begin
               rspData_d           = bus.dc_data_i;
               rspValid_d[grant_q] = 1'b1;
               pending_d[grant_q]  = 1'b0;
               rrPtr_d             = IDX_W'((int'(grant_q) + 1) % NUM_REQ);
            end
         end
         default: ;
      endcase
      busy_d = (state_d == WAIT) | (|pending_d);
   end

   // Registered outputs and arbitration bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q  <= '0;
         rrPtr_q    <= '0;
         grant_q    <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         dcValid_q  <= 1'b0;
         dcAddr_q   <= '0;
         dcData_q   <= '0;
         dcOp_q     <= '0;
         rspValid_q <= '0;
         rspData_q  <= '0;
      end else begin
         pending_q  <= pending_d;
         rrPtr_q    <= rrPtr_d;
         grant_q    <= grant_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         dcValid_q  <= dcValid_d;
         dcAddr_q   <= dcAddr_d;
         dcData_q   <= dcData_d;
         dcOp_q     <= dcOp_d;
         rspValid_q <= rspValid_d;
         rspData_q  <= rspData_d;
      end
   end

   // Per-requester slots latch the payload of every accepted pulse, bypass grants included.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            slotAddr_q[k] <= '0;
            slotData_q[k] <= '0;
            slotOp_q[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (capture[k]) begin
               slotAddr_q[k] <= bus.req_addr_i[AW*k +: AW];
               slotData_q[k] <= bus.req_data_i[DW*k +: DW];
               slotOp_q[k]   <= bus.req_op_i[3*k +: 3];
            end
         end
      end
   end

   assign bus.rsp_valid_o = rspValid_q;
   assign bus.rsp_data_o  = rspData_q;
   assign bus.dc_addr_o   = dcAddr_q;
   assign bus.dc_data_o   = dcData_q;
   assign bus.dc_op_o     = dcOp_q;
   assign bus.dc_valid_o  = dcValid_q;
   assign bus.busy_o      = busy_q;
   assign bus.err_o       = err_q;
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Testbench for dcache_port_arbiter: directed scenarios followed by a randomized soak
// checked against a transaction-level round-robin model and a simple cache responder.
module tb_dcache_port_arbiter;
   localparam int N            = 4;
   localparam int TX_COUNT     = 2000;
   localparam int CYCLE_BUDGET = 60000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   numChecks = 0;
   int   numErrors = 0;

   dcache_port_arbiter_if #(.NUM_REQ(N), .AW(32), .DW(32)) bus ();

   dcache_port_arbiter #(.NUM_REQ(N), .AW(32), .DW(32)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numErrors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Loads the payload slice of requester k.
   task automatic setPayload(input int k, input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
      bus.req_addr_i[32*k +: 32] = a;
      bus.req_data_i[32*k +: 32] = d;
      bus.req_op_i[3*k +: 3]     = op;
   endtask

   // Drives one cycle of pulses, lets the edge pass, and leaves us 1ns after it with pulses cleared.
   task automatic applyStimulus(input logic [N-1:0] pulses, input logic dcv, input logic [31:0] dcd);
      bus.req_valid_i = pulses;
      bus.dc_valid_i  = dcv;
      bus.dc_data_i   = dcd;
      @(posedge clk);
      #1;
      bus.req_valid_i = '0;
      bus.dc_valid_i  = 1'b0;
   endtask

   task automatic doReset();
      bus.req_valid_i = '0;
      bus.dc_valid_i  = 1'b0;
      bus.dc_data_i   = '0;
      bus.req_addr_i  = '0;
      bus.req_data_i  = '0;
      bus.req_op_i    = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Soak bookkeeping: model state, requester state, cache responder state.
   logic [N-1:0] mPend;
   logic [31:0]  mAddr [N];
   logic [31:0]  mData [N];
   logic [2:0]   mOp   [N];
   int           mRr, mGrant;
   bit           mBusy;
   logic [31:0]  inAddr [N];
   logic [31:0]  inData [N];
   logic [2:0]   inOp   [N];
   bit           reqOut [N];
   bit           awaitGrant [N];
   int           grantsSeen [N];
   int           issued, done, cycles, cacheCnt;
   bit           cacheActive, txOpen, found;
   logic [31:0]  cacheAddr;
   logic [N-1:0] pv, expRsp;
   logic         dcv, expDcV;
   logic [31:0]  dcd, expRspData, expAddr, expData;
   logic [2:0]   expOp;
   logic [31:0]  a4 [N];
   logic [31:0]  echo;
   int           g;

   initial begin
      // ---- Reset state ----
      doReset();
      checkOutput("reset_dc_valid", bus.dc_valid_o, 0);
      checkOutput("reset_rsp_valid", bus.rsp_valid_o, 0);
      checkOutput("reset_busy", bus.busy_o, 0);
      checkOutput("reset_err", bus.err_o, 0);
      checkOutput("reset_dc_addr", bus.dc_addr_o, 0);
      checkOutput("reset_rsp_data", bus.rsp_data_o, 0);

      // ---- Single request from requester 1 ----
      setPayload(1, 32'h100, 32'h0, 3'b001);
      applyStimulus(4'b0010, 1'b0, '0);
      checkOutput("t1_dc_valid", bus.dc_valid_o, 1);
      checkOutput("t1_dc_addr", bus.dc_addr_o, 32'h100);
      checkOutput("t1_dc_op", bus.dc_op_o, 3'b001);
      checkOutput("t1_busy", bus.busy_o, 1);
      applyStimulus('0, 1'b0, '0);
      checkOutput("t1_dc_valid_single", bus.dc_valid_o, 0);
      applyStimulus('0, 1'b0, '0);
      applyStimulus('0, 1'b0, '0);
      applyStimulus('0, 1'b1, 32'hDEADBEEF);
      checkOutput("t1_rsp_valid", bus.rsp_valid_o, 4'b0010);
      checkOutput("t1_rsp_data", bus.rsp_data_o, 32'hDEADBEEF);
      applyStimulus('0, 1'b0, '0);
      checkOutput("t1_rsp_pulse", bus.rsp_valid_o, 0);
      checkOutput("t1_idle_busy", bus.busy_o, 0);

      // ---- All four pulse together, cache latency 2 echoing the address ----
      doReset();
      for (int k = 0; k < N; k++) begin
         a4[k] = 32'h1000 + 32'(k) * 32'h10;
         setPayload(k, a4[k], 32'h0, 3'(k));
      end
      applyStimulus(4'b1111, 1'b0, '0);
      for (int n = 0; n < N; n++) begin
         checkOutput("t2_dc_valid", bus.dc_valid_o, 1);
         checkOutput("t2_grant_addr", bus.dc_addr_o, a4[n]);
         echo = bus.dc_addr_o;
         applyStimulus('0, 1'b0, '0);
         checkOutput("t2_dc_valid_drop", bus.dc_valid_o, 0);
         applyStimulus('0, 1'b1, echo);
         checkOutput("t2_rsp_valid", bus.rsp_valid_o, 64'(1) << n);
         checkOutput("t2_rsp_data", bus.rsp_data_o, a4[n]);
         applyStimulus('0, 1'b0, '0);
      end
      checkOutput("t2_done_dc_valid", bus.dc_valid_o, 0);
      checkOutput("t2_done_busy", bus.busy_o, 0);

      // ---- Rotation: after requester 2 completes, 3 beats 0 ----
      setPayload(2, 32'h2000, 32'h0, 3'b010);
      applyStimulus(4'b0100, 1'b0, '0);
      checkOutput("t3_first_addr", bus.dc_addr_o, 32'h2000);
      applyStimulus('0, 1'b1, 32'h22);
      checkOutput("t3_first_rsp", bus.rsp_valid_o, 4'b0100);
      setPayload(0, 32'h3000, 32'h0, 3'b000);
      setPayload(3, 32'h3300, 32'h0, 3'b011);
      applyStimulus(4'b1001, 1'b0, '0);
      checkOutput("t3_rr_first", bus.dc_addr_o, 32'h3300);
      applyStimulus('0, 1'b1, 32'h33);
      checkOutput("t3_rr_first_rsp", bus.rsp_valid_o, 4'b1000);
      applyStimulus('0, 1'b0, '0);
      checkOutput("t3_rr_second_valid", bus.dc_valid_o, 1);
      checkOutput("t3_rr_second", bus.dc_addr_o, 32'h3000);
      applyStimulus('0, 1'b1, 32'h30);
      checkOutput("t3_rr_second_rsp", bus.rsp_valid_o, 4'b0001);
      checkOutput("t3_err", bus.err_o, 0);

      // ---- Violation: requester 1 re-pulses while pending ----
      doReset();
      setPayload(0, 32'h4000, 32'h0, 3'b000);
      applyStimulus(4'b0001, 1'b0, '0);
      setPayload(1, 32'h111, 32'h0, 3'b001);
      applyStimulus(4'b0010, 1'b0, '0);
      checkOutput("t4_legal_capture_err", bus.err_o, 0);
      setPayload(1, 32'h222, 32'h0, 3'b111);
      applyStimulus(4'b0010, 1'b0, '0);
      checkOutput("t4_repulse_err", bus.err_o, 1);
      applyStimulus('0, 1'b1, 32'h40);
      checkOutput("t4_rsp0", bus.rsp_valid_o, 4'b0001);
      applyStimulus('0, 1'b0, '0);
      checkOutput("t4_slot1_addr", bus.dc_addr_o, 32'h111);
      checkOutput("t4_slot1_op", bus.dc_op_o, 3'b001);
      applyStimulus('0, 1'b1, 32'h41);
      checkOutput("t4_rsp1", bus.rsp_valid_o, 4'b0010);
      checkOutput("t4_err_sticky", bus.err_o, 1);

      // ---- Violation: response while idle ----
      doReset();
      checkOutput("t4b_err_cleared", bus.err_o, 0);
      applyStimulus('0, 1'b1, 32'h55);
      checkOutput("t4b_spurious_err", bus.err_o, 1);
      checkOutput("t4b_no_rsp", bus.rsp_valid_o, 0);

      // ---- Asynchronous reset in the middle of WAIT ----
      doReset();
      setPayload(2, 32'h5000, 32'h0, 3'b010);
      applyStimulus(4'b0100, 1'b0, '0);
      checkOutput("t5_pre_dc_valid", bus.dc_valid_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_async_dc_valid", bus.dc_valid_o, 0);
      checkOutput("t5_async_busy", bus.busy_o, 0);
      checkOutput("t5_async_dc_addr", bus.dc_addr_o, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus('0, 1'b0, '0);
      applyStimulus('0, 1'b1, 32'h77);
      checkOutput("t5_late_rsp_err", bus.err_o, 1);
      checkOutput("t5_late_no_rsp", bus.rsp_valid_o, 0);

      // ---- Randomized soak with legal traffic ----
      doReset();
      mPend = '0; mRr = 0; mGrant = 0; mBusy = 0;
      for (int k = 0; k < N; k++) begin
         reqOut[k] = 0; awaitGrant[k] = 0; grantsSeen[k] = 0;
      end
      issued = 0; done = 0; cycles = 0; cacheActive = 0; cacheCnt = 0; txOpen = 0;
      cacheAddr = '0; expRspData = '0; expAddr = '0; expData = '0; expOp = '0;
      while (done < TX_COUNT && cycles < CYCLE_BUDGET) begin
         pv = '0;
         for (int k = 0; k < N; k++) begin
            if (!reqOut[k] && issued < TX_COUNT && $urandom_range(0, 2) == 0) begin
               inAddr[k] = ($urandom & 32'hFFFF_FFFC) | 32'(k);
               inData[k] = $urandom;
               inOp[k]   = 3'($urandom_range(0, 7));
               setPayload(k, inAddr[k], inData[k], inOp[k]);
               pv[k] = 1'b1;
               reqOut[k] = 1; awaitGrant[k] = 1; grantsSeen[k] = 0;
               issued++;
            end
         end
         dcv = 1'b0; dcd = '0;
         if (cacheActive) begin
            cacheCnt--;
            if (cacheCnt == 0) begin
               dcv = 1'b1;
               dcd = cacheAddr ^ 32'h5A5A_A5A5;
               cacheActive = 0;
            end
         end
         // Reference: accept pulses into free slots; serve one request at a time, round-robin.
         expDcV = 1'b0; expRsp = '0;
         for (int k = 0; k < N; k++) begin
            if (pv[k] && !mPend[k]) begin
               mPend[k] = 1'b1; mAddr[k] = inAddr[k]; mData[k] = inData[k]; mOp[k] = inOp[k];
            end
         end
         if (mBusy) begin
            if (dcv) begin
               expRsp[mGrant] = 1'b1;
               expRspData = dcd;
               mPend[mGrant] = 1'b0;
               mRr = (mGrant + 1) % N;
               mBusy = 0;
            end
         end else begin
            found = 0;
            for (int i = 0; i < N; i++) begin
               if (!found && mPend[(mRr + i) % N]) begin
                  found = 1;
                  mGrant = (mRr + i) % N;
               end
            end
            if (found) begin
               expDcV = 1'b1; mBusy = 1;
               expAddr = mAddr[mGrant]; expData = mData[mGrant]; expOp = mOp[mGrant];
            end
         end
         applyStimulus(pv, dcv, dcd);
         cycles++;
         checkOutput("soak_dc_valid", bus.dc_valid_o, expDcV);
         checkOutput("soak_rsp_valid", bus.rsp_valid_o, expRsp);
         checkOutput("soak_err", bus.err_o, 0);
         if (bus.dc_valid_o) begin
            checkOutput("soak_overlap", txOpen, 0);
            checkOutput("soak_addr", bus.dc_addr_o, expAddr);
            checkOutput("soak_data", bus.dc_data_o, expData);
            checkOutput("soak_op", bus.dc_op_o, expOp);
            g = int'(bus.dc_addr_o[1:0]);
            checkOutput("soak_fairness", grantsSeen[g] <= N - 1, 1);
            awaitGrant[g] = 0;
            for (int k = 0; k < N; k++)
               if (k != g && awaitGrant[k]) grantsSeen[k]++;
            txOpen = 1;
            cacheActive = 1;
            cacheAddr = bus.dc_addr_o;
            cacheCnt = $urandom_range(1, 20);
         end
         if (|bus.rsp_valid_o) begin
            checkOutput("soak_rsp_data", bus.rsp_data_o, expRspData);
            for (int k = 0; k < N; k++) begin
               if (bus.rsp_valid_o[k]) begin
                  checkOutput("soak_answer_once", reqOut[k], 1);
                  reqOut[k] = 0;
                  done++;
               end
            end
            txOpen = 0;
         end
      end
      checkOutput("soak_all_answered", done, TX_COUNT);
      checkOutput("soak_issued_eq_done", issued, done);
      checkOutput("soak_final_err", bus.err_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecks, numErrors);
      $finish;
   end
endmodule
